// File: rtl/ps2_keyboard_rx_if.sv
// Key event stream between the PS/2 receiver (master) and its consumer (slave).
`timescale 1ns/1ps
interface ps2_keyboard_rx_if;
  logic       key_valid_o;
  logic       key_ready_i;
  logic [7:0] key_code_o;
  logic       key_extended_o;
  logic       key_release_o;

  modport master (
    output key_valid_o, key_code_o, key_extended_o, key_release_o,
    input  key_ready_i
  );

  modport slave (
    input  key_valid_o, key_code_o, key_extended_o, key_release_o,
    output key_ready_i
  );
endinterface

// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host receiver: pin conditioning, 11-bit deframer, E0/F0 prefix
// folding and a small event FIFO presented on a valid/ready stream.
`timescale 1ns/1ps
module ps2_keyboard_rx #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 20000,
  parameter int unsigned FIFO_DEPTH     = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  ps2_clk_i,
  input  logic                  ps2_data_i,
  ps2_keyboard_rx_if.master     key_if,
  output logic                  frame_err_o,
  output logic                  overflow_o
);
  localparam int unsigned FCNT_W = $clog2(FILTER_LEN + 1);
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } evt_t;

  typedef enum logic {IDLE, RECV} state_t;

  // Synchronisers and glitch filter on the PS/2 clock
  logic              clk_s1, clk_s2, data_s1, data_s2;
  logic              filt_clk, filt_prev;
  logic [FCNT_W-1:0] fcnt;
  logic              fall_c;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      clk_s1    <= 1'b1;
      clk_s2    <= 1'b1;
      data_s1   <= 1'b1;
      data_s2   <= 1'b1;
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
      fcnt      <= '0;
    end else begin
      clk_s1    <= ps2_clk_i;
      clk_s2    <= clk_s1;
      data_s1   <= ps2_data_i;
      data_s2   <= data_s1;
      filt_prev <= filt_clk;
      if (clk_s2 != filt_clk) begin
        if (fcnt == FCNT_W'(FILTER_LEN - 1)) begin
          filt_clk <= clk_s2;
          fcnt     <= '0;
        end else begin
          fcnt <= fcnt + FCNT_W'(1);
        end
      end else begin
        fcnt <= '0;
      end
    end
  end

  assign fall_c = filt_prev & ~filt_clk;

  // Deframer state
  state_t            state, state_d;
  logic [3:0]        bit_cnt, bit_cnt_d;
  logic [7:0]        shift, shift_d;
  logic              par, par_d;
  logic [TMO_W-1:0]  tmo, tmo_d;
  logic              byte_stb, stb_d, fsm_err_d;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shift    <= '0;
      par      <= 1'b0;
      tmo      <= '0;
      byte_stb <= 1'b0;
    end else begin
      state    <= state_d;
      bit_cnt  <= bit_cnt_d;
      shift    <= shift_d;
      par      <= par_d;
      tmo      <= tmo_d;
      byte_stb <= stb_d;
    end
  end

  always_comb begin
    state_d   = state;
    bit_cnt_d = bit_cnt;
    shift_d   = shift;
    par_d     = par;
    tmo_d     = tmo;
    stb_d     = 1'b0;
    fsm_err_d = 1'b0;
    case (state)
      IDLE: begin
        tmo_d = '0;
        if (fall_c) begin
          if (!data_s2) begin
            state_d   = RECV;
            bit_cnt_d = 4'd1;
          end else begin
            fsm_err_d = 1'b1;
          end
        end
      end
      RECV: begin
        if (fall_c) begin
          tmo_d     = '0;
          bit_cnt_d = bit_cnt + 4'd1;
          if (bit_cnt <= 4'd8) begin
            shift_d = {data_s2, shift[7:1]};
          end else if (bit_cnt == 4'd9) begin
            par_d = data_s2;
          end else begin
            state_d = IDLE;
            if ((^shift ^ par) && data_s2) stb_d     = 1'b1;
            else                            fsm_err_d = 1'b1;
          end
        end else if (tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d   = IDLE;
          fsm_err_d = 1'b1;
        end else begin
          tmo_d = tmo + TMO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Prefix folding; the completed byte stays in shift while the FSM idles
  logic ext, rel, ext_d, rel_d, push_c, dec_err_c;
  evt_t push_evt;

  always_comb begin
    ext_d     = ext;
    rel_d     = rel;
    push_c    = 1'b0;
    dec_err_c = 1'b0;
    if (byte_stb) begin
      if (shift == 8'hE0) begin
        ext_d = 1'b1;
      end else if (shift == 8'hF0) begin
        rel_d = 1'b1;
      end else if (shift == 8'h00 || shift == 8'hFF) begin
        ext_d     = 1'b0;
        rel_d     = 1'b0;
        dec_err_c = 1'b1;
      end else begin
        ext_d  = 1'b0;
        rel_d  = 1'b0;
        push_c = 1'b1;
      end
    end
  end

  assign push_evt = '{ext: ext, rel: rel, code: shift};

  // Event FIFO with a registered head
  evt_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_d;
  logic [CNT_W-1:0] count, count_d;
  logic             key_valid_q, pop_c, full_c, push_ok_c, ovf_c;
  evt_t             head_q, head_d;

  assign pop_c     = key_valid_q & key_if.key_ready_i;
  assign full_c    = (count == CNT_W'(FIFO_DEPTH));
  assign push_ok_c = push_c & (~full_c | pop_c);
  assign ovf_c     = push_c & full_c & ~pop_c;
  assign rd_ptr_d  = rd_ptr + PTR_W'(pop_c);
  assign count_d   = count + CNT_W'(push_ok_c) - CNT_W'(pop_c);
  assign head_d    = (push_ok_c && wr_ptr == rd_ptr_d) ? push_evt : mem[rd_ptr_d];

  always_ff @(posedge clk_i) begin
    if (push_ok_c) mem[wr_ptr] <= push_evt;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ext         <= 1'b0;
      rel         <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      key_valid_q <= 1'b0;
      head_q      <= '0;
      frame_err_o <= 1'b0;
      overflow_o  <= 1'b0;
    end else begin
      ext         <= ext_d;
      rel         <= rel_d;
      wr_ptr      <= wr_ptr + PTR_W'(push_ok_c);
      rd_ptr      <= rd_ptr_d;
      count       <= count_d;
      key_valid_q <= (count_d != '0);
      head_q      <= head_d;
      frame_err_o <= fsm_err_d | dec_err_c;
      overflow_o  <= ovf_c;
    end
  end

  assign key_if.key_valid_o    = key_valid_q;
  assign key_if.key_code_o     = head_q.code;
  assign key_if.key_extended_o = head_q.ext;
  assign key_if.key_release_o  = head_q.rel;
endmodule
